// File: rtl/endgame_ctrl.sv
// Endgame session controller: IDLE/RUN/END sequencing, game clock (s.hh), pair counting, win/time-out decision.
// All outputs registered; start and pair_found act on the sampling edge; no backpressure (pulse inputs only).
module endgame_ctrl #(
  parameter int TICK_DIV     = 650000,
  parameter int TIME_LIMIT_S = 60,
  parameter int PAIRS_TOTAL  = 8
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        start,
  input  logic        pair_found,
  output logic        running,
  output logic        enable,
  output logic        game_over_en,
  output logic [7:0]  discovered_pairs_ctr,
  output logic [12:0] game_time
);

  localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_END} state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [5:0]    sec_q, sec_d, sec_inc;
  logic [6:0]    hund_q, hund_d, hund_inc;
  logic [7:0]    pairs_q, pairs_d;
  logic          go_q, go_d;
  logic          tick, time_up, win;

  always_comb begin
    tick = (presc_q == PW'(TICK_DIV - 1));
    if (hund_q == 7'd99) begin
      hund_inc = 7'd0;
      sec_inc  = sec_q + 6'd1;
    end else begin
      hund_inc = hund_q + 7'd1;
      sec_inc  = sec_q;
    end
    // The limit can only be reached through a hundredths carry.
    time_up = tick && (hund_q == 7'd99) && (sec_inc == 6'(TIME_LIMIT_S));
    win     = pair_found && ((pairs_q + 8'd1) == 8'(PAIRS_TOTAL));
  end

  always_ff @(posedge pclk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (start) state_d = S_RUN;
      S_RUN:   if (win || time_up) state_d = S_END;
      S_END:   if (start) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    running = (state_q == S_RUN);
    enable  = (state_q == S_END);
  end

  always_comb begin
    presc_d = presc_q;
    sec_d   = sec_q;
    hund_d  = hund_q;
    pairs_d = pairs_q;
    go_d    = go_q;
    if ((state_q != S_RUN) && start) begin
      presc_d = '0;
      sec_d   = '0;
      hund_d  = '0;
      pairs_d = '0;
      go_d    = 1'b0;
    end else if (state_q == S_RUN) begin
      presc_d = tick ? '0 : presc_q + PW'(1);
      if (tick) begin
        sec_d  = sec_inc;
        hund_d = hund_inc;
      end
      if (pair_found) pairs_d = pairs_q + 8'd1;
      // A win in the same cycle as the time-out still counts as a win.
      if (win)          go_d = 1'b0;
      else if (time_up) go_d = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      presc_q <= '0;
      sec_q   <= '0;
      hund_q  <= '0;
      pairs_q <= '0;
      go_q    <= 1'b0;
    end else begin
      presc_q <= presc_d;
      sec_q   <= sec_d;
      hund_q  <= hund_d;
      pairs_q <= pairs_d;
      go_q    <= go_d;
    end
  end

  assign game_over_en         = go_q;
  assign discovered_pairs_ctr = pairs_q;
  assign game_time            = {sec_q, hund_q};

endmodule

// File: tb/tb_endgame_ctrl.sv
// Directed bench for endgame_ctrl with TICK_DIV=4, TIME_LIMIT_S=2, PAIRS_TOTAL=3.
module tb_endgame_ctrl;

  logic        pclk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        pair_found = 1'b0;
  logic        running, enable, game_over_en;
  logic [7:0]  discovered_pairs_ctr;
  logic [12:0] game_time;

  int vectors = 0;
  int miscompares = 0;

  endgame_ctrl #(.TICK_DIV(4), .TIME_LIMIT_S(2), .PAIRS_TOTAL(3)) dut (
    .pclk(pclk), .rst(rst), .start(start), .pair_found(pair_found),
    .running(running), .enable(enable), .game_over_en(game_over_en),
    .discovered_pairs_ctr(discovered_pairs_ctr), .game_time(game_time)
  );

  always #5 pclk = ~pclk;

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step(3);
    rst = 1'b0;
    step(20);
    vectors++;
    if ({running, enable, game_over_en} !== 3'b000) begin
      $display("FAIL reset_flags got %b want 000", {running, enable, game_over_en});
      miscompares++;
    end
    vectors++;
    if (game_time !== 13'd0 || discovered_pairs_ctr !== 8'd0) begin
      $display("FAIL reset_counts got gt=%0d pairs=%0d want 0 0", game_time, discovered_pairs_ctr);
      miscompares++;
    end
    pair_found = 1'b1;
    step(1);
    pair_found = 1'b0;
    step(1);
    vectors++;
    if (discovered_pairs_ctr !== 8'd0 || running !== 1'b0) begin
      $display("FAIL idle_pair got pairs=%0d running=%b want 0 0", discovered_pairs_ctr, running);
      miscompares++;
    end
  endtask

  task automatic test_timeout();
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++;
    if (running !== 1'b1 || game_time !== 13'd0) begin
      $display("FAIL to_enter got running=%b gt=%0d want 1 0", running, game_time);
      miscompares++;
    end
    step(3);
    vectors++;
    if (game_time !== 13'd0) begin
      $display("FAIL to_edge3 got gt=%0d want 0", game_time);
      miscompares++;
    end
    step(1);
    vectors++;
    if (game_time !== 13'd1) begin
      $display("FAIL to_first_tick got gt=%0d want 1", game_time);
      miscompares++;
    end
    step(395);
    vectors++;
    if (game_time !== 13'd99) begin
      $display("FAIL to_h99 got gt=%0d want 99", game_time);
      miscompares++;
    end
    step(1);
    vectors++;
    if (game_time !== 13'd128) begin
      $display("FAIL to_carry got gt=%0d want 128", game_time);
      miscompares++;
    end
    step(399);
    vectors++;
    if (game_time !== 13'd227 || running !== 1'b1 || enable !== 1'b0) begin
      $display("FAIL to_pre_limit got gt=%0d run=%b en=%b want 227 1 0", game_time, running, enable);
      miscompares++;
    end
    step(1);
    vectors++;
    if (game_time !== 13'd256 || {running, enable, game_over_en} !== 3'b011) begin
      $display("FAIL to_limit got gt=%0d flags=%b want 256 011", game_time, {running, enable, game_over_en});
      miscompares++;
    end
    pair_found = 1'b1;
    step(1);
    pair_found = 1'b0;
    step(49);
    vectors++;
    if (game_time !== 13'd256 || discovered_pairs_ctr !== 8'd0 || {running, enable, game_over_en} !== 3'b011) begin
      $display("FAIL to_frozen got gt=%0d pairs=%0d flags=%b want 256 0 011",
               game_time, discovered_pairs_ctr, {running, enable, game_over_en});
      miscompares++;
    end
  endtask

  task automatic test_restart_and_pairs();
    start = 1'b1;
    step(1);
    start = 1'b0;
    vectors++;
    if ({running, enable, game_over_en} !== 3'b100 || game_time !== 13'd0 || discovered_pairs_ctr !== 8'd0) begin
      $display("FAIL restart got flags=%b gt=%0d pairs=%0d want 100 0 0",
               {running, enable, game_over_en}, game_time, discovered_pairs_ctr);
      miscompares++;
    end
    step(1);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(2);
    vectors++;
    if (game_time !== 13'd1 || running !== 1'b1) begin
      $display("FAIL start_in_run got gt=%0d running=%b want 1 1", game_time, running);
      miscompares++;
    end
    for (int i = 0; i < 3; i++) begin
      step(9);
      pair_found = 1'b1;
      step(1);
      pair_found = 1'b0;
      vectors++;
      if (discovered_pairs_ctr !== 8'(i + 1)) begin
        $display("FAIL pair_count%0d got %0d want %0d", i, discovered_pairs_ctr, i + 1);
        miscompares++;
      end
    end
    vectors++;
    if ({running, enable, game_over_en} !== 3'b010) begin
      $display("FAIL win_flags got %b want 010", {running, enable, game_over_en});
      miscompares++;
    end
    step(3);
    pair_found = 1'b1;
    step(1);
    pair_found = 1'b0;
    step(1);
    vectors++;
    if (discovered_pairs_ctr !== 8'd3 || enable !== 1'b1) begin
      $display("FAIL fourth_pair got pairs=%0d en=%b want 3 1", discovered_pairs_ctr, enable);
      miscompares++;
    end
  endtask

  task automatic test_win_timeout_tie();
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(9);
      pair_found = 1'b1;
      step(1);
      pair_found = 1'b0;
    end
    step(779);
    vectors++;
    if (game_time !== 13'd227 || discovered_pairs_ctr !== 8'd2 || running !== 1'b1) begin
      $display("FAIL tie_pre got gt=%0d pairs=%0d run=%b want 227 2 1", game_time, discovered_pairs_ctr, running);
      miscompares++;
    end
    pair_found = 1'b1;
    step(1);
    pair_found = 1'b0;
    vectors++;
    if (game_time !== 13'd256 || discovered_pairs_ctr !== 8'd3 || {running, enable, game_over_en} !== 3'b010) begin
      $display("FAIL tie got gt=%0d pairs=%0d flags=%b want 256 3 010",
               game_time, discovered_pairs_ctr, {running, enable, game_over_en});
      miscompares++;
    end
  endtask

  task automatic test_reset_mid_run();
    start = 1'b1;
    step(1);
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(9);
      pair_found = 1'b1;
      step(1);
      pair_found = 1'b0;
    end
    step(2);
    vectors++;
    if (discovered_pairs_ctr !== 8'd2 || game_time !== 13'd5) begin
      $display("FAIL mid_run got pairs=%0d gt=%0d want 2 5", discovered_pairs_ctr, game_time);
      miscompares++;
    end
    rst = 1'b1;
    step(1);
    rst = 1'b0;
    vectors++;
    if ({running, enable, game_over_en} !== 3'b000 || discovered_pairs_ctr !== 8'd0 || game_time !== 13'd0) begin
      $display("FAIL mid_reset got flags=%b pairs=%0d gt=%0d want 000 0 0",
               {running, enable, game_over_en}, discovered_pairs_ctr, game_time);
      miscompares++;
    end
    step(5);
    start = 1'b1;
    step(1);
    start = 1'b0;
    step(3);
    vectors++;
    if (game_time !== 13'd0 || running !== 1'b1) begin
      $display("FAIL post_reset_edge3 got gt=%0d run=%b want 0 1", game_time, running);
      miscompares++;
    end
    step(1);
    vectors++;
    if (game_time !== 13'd1) begin
      $display("FAIL post_reset_tick got gt=%0d want 1", game_time);
      miscompares++;
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_timeout();
    test_restart_and_pairs();
    test_win_timeout_tie();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/endgame_ctrl.md
# endgame_ctrl

Game-session controller that sequences the endgame screen. It runs the session state machine (idle, running, ended), keeps the game clock in seconds and hundredths, counts discovered pairs, and decides the end condition: win or time-out. Its registered outputs drive the end screen's enable, game-over flag, pair count and game-time inputs directly. The board-level logic supplies start and pair-found pulses.

## Interface
Parameters:
- TICK_DIV, 650000: pclk cycles per hundredth of a second (65 MHz / 100); must be ≥2.
- TIME_LIMIT_S, 60: session length in seconds, range 1..63.
- PAIRS_TOTAL, 8: pairs on the board, range 1..99.

Ports:
- pclk  in  1  pixel clock, the only clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse that starts or restarts a session.
- pair_found  in  1  one-cycle pulse, one pair matched.
- running  out  1  high while in RUN.
- enable  out  1  end-screen enable, high while in END.
- game_over_en  out  1  1 = time expired (lost), 0 = all pairs found (won); meaningful in END.
- discovered_pairs_ctr  out  8  binary pair count.
- game_time  out  13  {seconds[5:0], hundredths[6:0]}, both binary; hundredths range 0..99.

## Operation
States and transitions:
- IDLE: after reset.
  - start → RUN.
- RUN: the session is in progress.
  - last pair found → END with game_over_en=0.
  - time limit reached → END with game_over_en=1.
- END: the result screen is shown.
  - start → RUN (restart).

Entering RUN:
- Clear the prescaler, game_time and discovered_pairs_ctr in the same edge that enters RUN.
- This applies both from IDLE and on a restart from END.

Game clock (RUN only):
- The prescaler counts 0..TICK_DIV-1.
- On the wrap cycle the hundredths field increments.
- Hundredths 99 → 0 carries 1 into seconds.

Pair counter (RUN only):
- Each pair_found pulse increments discovered_pairs_ctr by 1.
- The counter never exceeds PAIRS_TOTAL.

End detection (RUN only):
- Time-out: the clock update would produce {TIME_LIMIT_S, 0}. Store that value, set game_over_en=1, go to END.
- Win: the pair increment would make the count equal PAIRS_TOTAL. Store it, set game_over_en=0, go to END.
- Both in the same cycle: the win takes priority. Both updates are stored and game_over_en=0.

In END:
- All counters are frozen.
- pair_found is ignored.
- game_over_en holds.

Ignored inputs:
- start while in RUN.
- pair_found in IDLE.

## Timing
Reset values: state IDLE; running=0, enable=0, game_over_en=0, discovered_pairs_ctr=0, game_time=0, prescaler=0.

Reset behaviour: reset dominates every other input, including when asserted mid-RUN or in END; the block returns to IDLE on the next edge.

All outputs are registered, with no combinational path from any input to any output.

Latencies, counted from the edge that samples the input:
- start in IDLE or END: running=1, and enable=0 if coming from END, from the same edge.
- pair_found: discovered_pairs_ctr updates on the same edge.
- Final pair_found: enable=1, running=0 and game_over_en=0, all on the same edge as the counter update.
- Time-out: the edge that stores {TIME_LIMIT_S,0} also sets enable=1, running=0 and game_over_en=1.

Clock rate: exactly one hundredth per TICK_DIV cycles in RUN. The first increment happens TICK_DIV edges after entering RUN.

Restart: on start in END, game_over_en returns to 0 on the same edge.

## Test plan
Bench parameters: TICK_DIV=4, TIME_LIMIT_S=2, PAIRS_TOTAL=3.

- Reset then idle 20 cycles → all outputs 0; pair_found in IDLE leaves discovered_pairs_ctr=0.
- start, then run 400 cycles → hundredths counts 0..99, wraps to seconds=1; after 800 cycles in RUN game_time={2,0}, enable=1, game_over_en=1, running=0; counters stay frozen for 50 more cycles.
- start, then three pair_found pulses 10 cycles apart → discovered_pairs_ctr 1,2,3; on the third pulse's edge enable=1, game_over_en=0; a fourth pulse leaves the count at 3.
- Third pair_found on the same cycle as the hundredths 99→0 carry that hits the limit → enable=1, game_over_en=0, discovered_pairs_ctr=3, game_time={2,0}.
- start in END → next edge: running=1, enable=0, game_over_en=0, game_time=0, discovered_pairs_ctr=0; start pulses during RUN change nothing.
- rst asserted mid-RUN with discovered_pairs_ctr=2 → next edge: IDLE, all outputs 0; the prescaler restarts from 0 on the next start.
